// File: rtl/wb_regfile.sv
// Write-back stage and register file.
// Selects the MEM/WB write-back value, commits it to a flop-based register
// file with asynchronous clear, and serves two combinational read ports with
// a same-cycle write-to-read bypass so ID never stalls on a WB write.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_In,
    input  logic              MemtoReg_Select_In,
    input  logic [DATA_W-1:0] readDataMem_In,
    input  logic [DATA_W-1:0] aluResult_In,
    input  logic [ADDR_W-1:0] instruOut2_In,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              dest_zero;

    // Write-back source select and qualified write enable.
    // The AND with RegWrite_In comes first so an X destination cannot leak
    // into wb_we when no write is requested.
    always_comb begin
        wb_data   = MemtoReg_Select_In ? readDataMem_In : aluResult_In;
        dest_zero = (ZERO_REG != 0) && (instruOut2_In == '0);
        wb_we     = RegWrite_In & ~reset & ~dest_zero;
    end

    // Storage: async clear on reset, single-edge commit otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[instruOut2_In] <= wb_data;
        end
    end

    // Read port A: reset forces 0, register 0 reads 0, then bypass, then storage.
    always_comb begin
        rs_data = '0;
        if (reset) begin
            rs_data = '0;
        end else if ((ZERO_REG != 0) && (rs_addr == '0)) begin
            rs_data = '0;
        end else if (wb_we & (instruOut2_In == rs_addr)) begin
            rs_data = wb_data;
        end else begin
            rs_data = regs[rs_addr];
        end
    end

    // Read port B: identical rule to port A using rt_addr.
    always_comb begin
        rt_data = '0;
        if (reset) begin
            rt_data = '0;
        end else if ((ZERO_REG != 0) && (rt_addr == '0)) begin
            rt_data = '0;
        end else if (wb_we & (instruOut2_In == rt_addr)) begin
            rt_data = wb_data;
        end else begin
            rt_data = regs[rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite_In;
    logic        MemtoReg_Select_In;
    logic [31:0] readDataMem_In;
    logic [31:0] aluResult_In;
    logic [4:0]  instruOut2_In;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        wb_we;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk                (clk),
        .reset              (reset),
        .RegWrite_In        (RegWrite_In),
        .MemtoReg_Select_In (MemtoReg_Select_In),
        .readDataMem_In     (readDataMem_In),
        .aluResult_In       (aluResult_In),
        .instruOut2_In      (instruOut2_In),
        .rs_addr            (rs_addr),
        .rt_addr            (rt_addr),
        .rs_data            (rs_data),
        .rt_data            (rt_data),
        .wb_data            (wb_data),
        .wb_we              (wb_we)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic sel, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] dest);
        RegWrite_In        = we;
        MemtoReg_Select_In = sel;
        readDataMem_In     = mem;
        aluResult_In       = alu;
        instruOut2_In      = dest;
    endtask

    // Directed stimulus: inputs change at negedge, checks 1 unit later.
    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #3;
        chk("reset_rs", rs_data, 32'h0);
        chk("reset_we", {31'b0, wb_we}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Test 2: ALU source write to reg 7, then memory source.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd7);
        rs_addr = 5'd7; rt_addr = 5'd1;
        #1;
        chk("t2_bypass_rs", rs_data, 32'hDEADBEEF);
        chk("t2_wb_data", wb_data, 32'hDEADBEEF);
        chk("t2_wb_we", {31'b0, wb_we}, 32'h1);
        chk("t2_rt_other", rt_data, 32'h0);
        @(posedge clk); #1;
        RegWrite_In = 1'b0;
        #1;
        chk("t2_stored_alu", rs_data, 32'hDEADBEEF);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0000CAFE, 32'h12345678, 5'd7);
        #1;
        chk("t2_mem_wb_data", wb_data, 32'h0000CAFE);
        chk("t2_mem_bypass", rs_data, 32'h0000CAFE);
        @(posedge clk); #1;
        RegWrite_In = 1'b0;
        #1;
        chk("t2_stored_mem", rs_data, 32'h0000CAFE);

        // Test 4: reg 3 = 0x11, then a disabled write must not change it.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd3);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h55, 5'd3);
        rs_addr = 5'd3;
        #1;
        chk("t4_no_bypass", rs_data, 32'h11);
        chk("t4_wb_we", {31'b0, wb_we}, 32'h0);
        chk("t4_wb_data", wb_data, 32'h55);
        @(posedge clk); #1;
        chk("t4_unchanged", rs_data, 32'h11);

        // Test 3: write to register 0 is dropped.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        chk("t3_wb_we", {31'b0, wb_we}, 32'h0);
        chk("t3_rs_pre", rs_data, 32'h0);
        chk("t3_rt_pre", rt_data, 32'h0);
        @(posedge clk); #1;
        chk("t3_rs_post", rs_data, 32'h0);
        chk("t3_rt_post", rt_data, 32'h0);

        // Test 5: same address on both ports, then back-to-back writes.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd9);
        rs_addr = 5'd9; rt_addr = 5'd9;
        #1;
        chk("t5_rs_same", rs_data, 32'hA5A5A5A5);
        chk("t5_rt_same", rt_data, 32'hA5A5A5A5);
        for (int v = 1; v <= 3; v++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h0, v, 5'd9);
            #1;
            chk("t5_b2b_rs", rs_data, v);
            chk("t5_b2b_rt", rt_data, v);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd9);
        #1;
        chk("t5_final", rs_data, 32'h3);

        // X on data/dest with RegWrite_In = 0 must not disturb storage or reads.
        @(negedge clk);
        drive(1'b0, 1'bx, 32'hx, 32'hx, 5'bx);
        rs_addr = 5'd9; rt_addr = 5'd7;
        #1;
        chk("x_wb_we", {31'b0, wb_we}, 32'h0);
        chk("x_rs", rs_data, 32'h3);
        chk("x_rt", rt_data, 32'h0000CAFE);
        @(posedge clk); #1;
        chk("x_rs_post", rs_data, 32'h3);

        // Test 1: reg 5 = 0x1234, then a mid-cycle reset pulse.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd5);
        rs_addr = 5'd5;
        #1;
        chk("t1_pre_reset", rs_data, 32'h1234);
        #1;
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h9999, 5'd5);
        #1;
        chk("t1_during_rs", rs_data, 32'h0);
        chk("t1_during_we", {31'b0, wb_we}, 32'h0);
        chk("t1_during_wbdata", wb_data, 32'h9999);
        @(posedge clk); #2;
        RegWrite_In = 1'b0;
        reset = 1'b0;
        #1;
        chk("t1_after_rs", rs_data, 32'h0);
        for (int a = 0; a < 32; a++) begin
            rs_addr = a[4:0];
            rt_addr = 5'(31 - a);
            #1;
            chk("t1_all_rs", rs_data, 32'h0);
            chk("t1_all_rt", rt_data, 32'h0);
        end

        // First commit after release lands at the next enabled edge.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h66, 5'd6);
        @(posedge clk); #1;
        RegWrite_In = 1'b0;
        rs_addr = 5'd6;
        #1;
        chk("t1_first_commit", rs_data, 32'h66);

        // Test 6: reset coincident with a write edge.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h99, 5'd4);
        @(negedge clk);
        RegWrite_In = 1'b0;
        rs_addr = 5'd4;
        #1;
        chk("t6_pre", rs_data, 32'h99);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd4);
        @(posedge clk);
        reset = 1'b1;
        #2;
        RegWrite_In = 1'b0;
        reset = 1'b0;
        #1;
        chk("t6_after", rs_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
